// File: rtl/cpu_datapath_core.sv
// cpu_datapath_core: execution datapath of the 16-bit processor, built around
// one internal data bus that links a register file, an ALU with flags, the
// program counter and a data RAM.
// Latency: bus reads are combinational (zero cycles), and every write commits on
// the rising clk edge. There is no backpressure: the sequencer drives enables every cycle.
// Ports:
//   clk, reset                 rising-edge clock; asynchronous active-high reset
//   opcode, operand            current instruction words from the sequencer
//   data_in                    external bus value, used when no internal source is read
//   reg_read_en/reg_write_en   reg[opcode[3:0]] drives the bus / is written from the bus
//   ram_read_en/ram_write_en   ram[operand[7:0]] drives the bus / is written from the bus
//   pc_read_en, pc_en          PC drives the bus / PC advances or branches
//   alu_exec_en                execute the ALU instruction (opcode[15:12] == 1)
//   data_out, data_out_valid   bus value; high when any read enable is active
//   flags                      {V,N,C,Z}
//   pc                         current program counter
module cpu_datapath_core #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  reg_read_en,
  input  logic                  reg_write_en,
  input  logic                  alu_exec_en,
  input  logic                  ram_read_en,
  input  logic                  ram_write_en,
  input  logic                  pc_read_en,
  input  logic                  pc_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [3:0]            flags,
  output logic [DATA_WIDTH-1:0] pc
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int MSB    = DATA_WIDTH - 1;

  // State
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [3:0]            flags_q, flags_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ram_q [RAM_DEPTH];

  // Instruction fields
  logic [3:0]        reg_idx;
  logic [3:0]        alu_fn, rd_idx, rs1_idx, rs2_idx;
  logic [RAM_AW-1:0] ram_addr;

  assign reg_idx  = opcode[3:0];
  assign alu_fn   = opcode[11:8];
  assign rd_idx   = operand[11:8];
  assign rs1_idx  = operand[7:4];
  assign rs2_idx  = operand[3:0];
  assign ram_addr = operand[RAM_AW-1:0];

  // These instruction bits carry no meaning for this datapath.
  logic unused_bits;
  assign unused_bits = ^{opcode[7:4], operand[DATA_WIDTH-1:12]};

  // Internal bus
  logic [DATA_WIDTH-1:0] bus;

  always_comb begin
    bus = data_in;
    if (reg_read_en)      bus = regs_q[reg_idx];
    else if (ram_read_en) bus = ram_q[ram_addr];
    else if (pc_read_en)  bus = pc_q;
  end

  assign data_out       = bus;
  assign data_out_valid = reg_read_en | ram_read_en | pc_read_en;

  // ALU
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, alu_res;
  logic [DATA_WIDTH:0]   sum_ext, diff_ext;
  logic                  alu_c, alu_v;
  logic                  alu_valid, alu_wb;

  assign rs1_val   = regs_q[rs1_idx];
  assign rs2_val   = regs_q[rs2_idx];
  // Functions 10-15 are reserved and behave as no-ops.
  assign alu_valid = alu_exec_en && (opcode[15:12] == 4'h1) && (alu_fn <= 4'd9);
  assign alu_wb    = alu_valid && (alu_fn != 4'd9);   // CMP only sets flags

  always_comb begin
    sum_ext  = {1'b0, rs1_val} + {1'b0, rs2_val};
    diff_ext = {1'b0, rs1_val} - {1'b0, rs2_val};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (alu_fn)
      4'd0: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = (rs1_val[MSB] == rs2_val[MSB]) && (alu_res[MSB] != rs1_val[MSB]);
      end
      4'd1, 4'd9: begin
        alu_res = diff_ext[MSB:0];
        alu_c   = diff_ext[DATA_WIDTH];            // borrow out
        alu_v   = (rs1_val[MSB] != rs2_val[MSB]) && (alu_res[MSB] != rs1_val[MSB]);
      end
      4'd2: alu_res = rs1_val & rs2_val;
      4'd3: alu_res = rs1_val | rs2_val;
      4'd4: alu_res = rs1_val ^ rs2_val;
      4'd5: alu_res = ~rs1_val;
      4'd6: begin
        alu_res = {rs1_val[MSB-1:0], 1'b0};
        alu_c   = rs1_val[MSB];
      end
      4'd7: begin
        alu_res = {1'b0, rs1_val[MSB:1]};
        alu_c   = rs1_val[0];
      end
      4'd8: alu_res = rs1_val;
      default: alu_res = '0;
    endcase
  end

  // Next state: register file and flags
  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (reg_write_en) regs_d[reg_idx] = bus;
    // Applied after the bus write so the ALU result wins a same-register collision.
    if (alu_wb) regs_d[rd_idx] = alu_res;
    if (alu_valid) flags_d = {alu_v, alu_res[MSB], alu_c, (alu_res == '0)};
  end

  // Next state: program counter. Branches test the flags from before this edge.
  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (opcode[11:8])
      4'd0:    br_taken = 1'b1;
      4'd1:    br_taken = flags_q[0];
      4'd2:    br_taken = !flags_q[0];
      4'd3:    br_taken = flags_q[1];
      4'd4:    br_taken = !flags_q[1];
      default: br_taken = 1'b0;
    endcase

    pc_d = pc_q;
    if (pc_en) begin
      if ((opcode[15:12] == 4'h7) && br_taken) pc_d = operand;
      else                                     pc_d = pc_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flags_q <= '0;
      pc_q    <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
      pc_q    <= pc_d;
    end
  end

  // RAM has no reset. Gating the write with reset drops a write that would otherwise land while reset is held.
  always_ff @(posedge clk) begin
    if (ram_write_en && !reset) ram_q[ram_addr] <= bus;
  end

  assign flags = flags_q;
  assign pc    = pc_q;

endmodule

// File: tb/tb_cpu_datapath_core.sv
module tb_cpu_datapath_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] opcode, operand, data_in;
  logic        reg_read_en, reg_write_en, alu_exec_en;
  logic        ram_read_en, ram_write_en, pc_read_en, pc_en;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic [3:0]  flags;
  logic [15:0] pc;

  cpu_datapath_core dut (
    .clk(clk), .reset(reset), .opcode(opcode), .operand(operand), .data_in(data_in),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en), .alu_exec_en(alu_exec_en),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en), .pc_read_en(pc_read_en),
    .pc_en(pc_en), .data_out(data_out), .data_out_valid(data_out_valid),
    .flags(flags), .pc(pc)
  );

  always #5 clk = ~clk;

  // Control word bit positions: {rr, rw, alu, mr, mw, pr, pe}
  localparam logic [6:0] RR  = 7'b1000000;
  localparam logic [6:0] RW  = 7'b0100000;
  localparam logic [6:0] ALU = 7'b0010000;
  localparam logic [6:0] MR  = 7'b0001000;
  localparam logic [6:0] MW  = 7'b0000100;
  localparam logic [6:0] PR  = 7'b0000010;
  localparam logic [6:0] PE  = 7'b0000001;
  localparam logic [6:0] NONE = 7'b0000000;

  typedef struct {
    logic [6:0]  ctl;
    logic [15:0] opc, opd, din;
    logic [15:0] exp_do;
    logic        exp_vld;
    logic [15:0] exp_pc;
    logic [3:0]  exp_fl;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int m_reg[16];
  int m_ram[256];
  bit m_wr[256];
  int m_pc;
  int m_fl;   // bit0 Z, bit1 C, bit2 N, bit3 V

  function automatic vec_t mk(logic [6:0] ctl, logic [15:0] opc, logic [15:0] opd,
                              logic [15:0] din, logic [15:0] exp_do, logic exp_vld,
                              logic [15:0] exp_pc, logic [3:0] exp_fl);
    vec_t v;
    v.ctl = ctl; v.opc = opc; v.opd = opd; v.din = din;
    v.exp_do = exp_do; v.exp_vld = exp_vld; v.exp_pc = exp_pc; v.exp_fl = exp_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] ctl, input logic [15:0] opc,
                       input logic [15:0] opd, input logic [15:0] din);
    reg_read_en  = ctl[6];
    reg_write_en = ctl[5];
    alu_exec_en  = ctl[4];
    ram_read_en  = ctl[3];
    ram_write_en = ctl[2];
    pc_read_en   = ctl[1];
    pc_en        = ctl[0];
    opcode = opc; operand = opd; data_in = din;
  endtask

  function automatic int to_signed16(int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Advances the model by one clock edge, given this cycle's inputs and bus value.
  task automatic model_step(input logic [6:0] ctl, input logic [15:0] opc,
                            input logic [15:0] opd, input int bus);
    int a, b, r, sr, res, f;
    bit c, v, taken;
    int new_reg[16];
    int new_fl, new_pc;
    new_reg = m_reg;
    new_fl  = m_fl;
    new_pc  = m_pc;
    if (ctl[5]) new_reg[opc[3:0]] = bus;
    f = opc[11:8];
    if (ctl[4] && opc[15:12] == 4'h1 && f <= 9) begin
      a = m_reg[opd[7:4]];
      b = m_reg[opd[3:0]];
      c = 0; v = 0; r = 0; sr = 0;
      case (f)
        0: begin r = a + b; c = (r > 65535); sr = to_signed16(a) + to_signed16(b);
                 v = (sr > 32767) || (sr < -32768); end
        1, 9: begin r = a - b; c = (a < b); sr = to_signed16(a) - to_signed16(b);
                    v = (sr > 32767) || (sr < -32768); end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = 65535 - a;
        6: begin r = a * 2; c = (a >= 32768); end
        7: begin r = a / 2; c = (a % 2) == 1; end
        default: r = a;
      endcase
      res = r & 16'hFFFF;
      if (f != 9) new_reg[opd[11:8]] = res;
      new_fl = (res == 0 ? 1 : 0) + (c ? 2 : 0) + (res >= 32768 ? 4 : 0) + (v ? 8 : 0);
    end
    if (ctl[2]) begin
      m_ram[opd[7:0]] = bus;
      m_wr[opd[7:0]]  = 1'b1;
    end
    if (ctl[0]) begin
      case (opc[11:8])
        0: taken = 1;
        1: taken = (m_fl & 1) != 0;
        2: taken = (m_fl & 1) == 0;
        3: taken = (m_fl & 2) != 0;
        4: taken = (m_fl & 2) == 0;
        default: taken = 0;
      endcase
      if (opc[15:12] == 4'h7 && taken) new_pc = opd;
      else                             new_pc = (m_pc + 1) % 65536;
    end
    m_reg = new_reg;
    m_fl  = new_fl;
    m_pc  = new_pc;
  endtask

  initial begin
    reset = 1'b1;
    drive(NONE, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_flags", {12'h0, flags}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: inputs held for one cycle, bus checked before the edge,
    // pc/flags checked after it.
    vecs.push_back(mk(RR,      16'h0005, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 4'h0));
    vecs.push_back(mk(MW,      16'h4100, 16'h0010, 16'h1234, 16'h1234, 0, 16'h0000, 4'h0));
    vecs.push_back(mk(MR,      16'h0000, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 4'h0));
    vecs.push_back(mk(MR|RW,   16'h9203, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 4'h0));
    vecs.push_back(mk(RR,      16'h0003, 16'h0000, 16'h0000, 16'h1234, 1, 16'h0000, 4'h0));
    vecs.push_back(mk(RW,      16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 4'h0));
    vecs.push_back(mk(RW,      16'h0002, 16'h0000, 16'h0001, 16'h0001, 0, 16'h0000, 4'h0));
    vecs.push_back(mk(ALU,     16'h1000, 16'h0312, 16'h0000, 16'h0000, 0, 16'h0000, 4'h3));
    vecs.push_back(mk(RR,      16'h0003, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(RR|MR,   16'h0003, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(MR|PR,   16'h0000, 16'h0010, 16'h0000, 16'h1234, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(ALU,     16'h1900, 16'h0021, 16'h0000, 16'h0000, 0, 16'h0000, 4'h2));
    vecs.push_back(mk(RR,      16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 4'h2));
    vecs.push_back(mk(PE,      16'h7300, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0040, 4'h2));
    vecs.push_back(mk(PE,      16'h7100, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0041, 4'h2));
    vecs.push_back(mk(NONE,    16'h7000, 16'h1111, 16'h0000, 16'h0000, 0, 16'h0041, 4'h2));
    vecs.push_back(mk(PR,      16'h0000, 16'h0000, 16'h0000, 16'h0041, 1, 16'h0041, 4'h2));
    vecs.push_back(mk(PE,      16'h7000, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'hFFFF, 4'h2));
    vecs.push_back(mk(PE,      16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 4'h2));
    vecs.push_back(mk(ALU|RW,  16'h1804, 16'h0410, 16'h5555, 16'h5555, 0, 16'h0000, 4'h4));
    vecs.push_back(mk(RR,      16'h0004, 16'h0000, 16'h0000, 16'hFFFF, 1, 16'h0000, 4'h4));
    vecs.push_back(mk(ALU|RW,  16'h1006, 16'h0512, 16'h00AA, 16'h00AA, 0, 16'h0000, 4'h3));
    vecs.push_back(mk(RR,      16'h0006, 16'h0000, 16'h0000, 16'h00AA, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(RR,      16'h0005, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(ALU,     16'h1A00, 16'h0712, 16'h0000, 16'h0000, 0, 16'h0000, 4'h3));
    vecs.push_back(mk(RR,      16'h0007, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(ALU,     16'h2000, 16'h0812, 16'h0000, 16'h0000, 0, 16'h0000, 4'h3));
    vecs.push_back(mk(RR,      16'h0008, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 4'h3));
    vecs.push_back(mk(PE,      16'h7100, 16'h0123, 16'h0000, 16'h0000, 0, 16'h0123, 4'h3));
    vecs.push_back(mk(PE,      16'h7400, 16'h0500, 16'h0000, 16'h0000, 0, 16'h0124, 4'h3));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ctl, vecs[i].opc, vecs[i].opd, vecs[i].din);
      #1;
      chk($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_do);
      chk($sformatf("vec%0d_valid", i), {15'h0, data_out_valid}, {15'h0, vecs[i].exp_vld});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_flags", i), {12'h0, flags}, {12'h0, vecs[i].exp_fl});
    end

    // Reset mid-cycle, held across an edge that carries a register write.
    @(negedge clk);
    drive(RW, 16'h0008, 16'h0000, 16'hBEEF);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_pc", pc, 16'h0000);
    chk("midreset_flags", {12'h0, flags}, 16'h0000);
    chk("midreset_bus", data_out, 16'hBEEF);
    @(posedge clk);
    #1;
    drive(NONE, 16'h0, 16'h0, 16'h0);
    reset = 1'b0;
    @(negedge clk);
    drive(RR, 16'h0008, 16'h0000, 16'h0000);
    #1;
    chk("midreset_dropped_write", data_out, 16'h0000);
    @(negedge clk);
    drive(RR, 16'h0004, 16'h0000, 16'h0000);
    #1;
    chk("midreset_reg4_cleared", data_out, 16'h0000);

    // Randomized phase against the reference model, starting from a fresh reset.
    @(negedge clk);
    drive(NONE, 16'h0, 16'h0, 16'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    for (int i = 0; i < 256; i++) begin m_ram[i] = 0; m_wr[i] = 1'b0; end
    m_pc = 0;
    m_fl = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [6:0]  ctl;
      logic [15:0] opc, opd, din;
      logic [3:0]  top;
      int exp_bus;
      @(negedge clk);
      ctl = 7'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    top = 4'h1;
        2:       top = 4'h7;
        default: top = 4'($urandom);
      endcase
      opc = {top, 12'($urandom)};
      if (top == 4'h7) opc[11:8] = 4'($urandom_range(0, 5));
      opd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) opd[7:4] = 4'h0;  // reuse a few RAM words often
      din = 16'($urandom);
      // Never source the bus from an unwritten RAM word.
      if (ctl[3] && !ctl[6] && !m_wr[opd[7:0]]) ctl[3] = 1'b0;
      if (ctl[6])      exp_bus = m_reg[opc[3:0]];
      else if (ctl[3]) exp_bus = m_ram[opd[7:0]];
      else if (ctl[1]) exp_bus = m_pc;
      else             exp_bus = din;
      drive(ctl, opc, opd, din);
      #1;
      chk("rand_data_out", data_out, 16'(exp_bus));
      chk("rand_valid", {15'h0, data_out_valid}, {15'h0, (ctl[6] | ctl[3] | ctl[1])});
      model_step(ctl, opc, opd, exp_bus);
      @(posedge clk);
      #1;
      chk("rand_pc", pc, 16'(m_pc));
      chk("rand_flags", {12'h0, flags}, 16'(m_fl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath_core.md
Name: cpu_datapath_core

Overview:
- Execution datapath of the 16-bit fetch-decode-execute processor: register file + ALU with flags, program counter, and data RAM behind one internal data bus.
- The sequencer supplies the current instruction (opcode and operand words) and one-hot-style control enables each cycle.
- The block sources the bus from a register, RAM or the PC, or passes data_in through.
- Writes to registers and RAM take the bus value at the clock edge.

Parameters:
- DATA_WIDTH, 16, datapath width; opcode, operand, PC and data are all this width.
- NUM_REGS, 16, general registers, indexed by 4-bit fields.
- RAM_DEPTH, 256, RAM words, addressed by operand[7:0].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  16  instruction opcode word.
- operand  in  16  instruction operand word.
- data_in  in  16  external bus value; used when no internal source is enabled.
- reg_read_en  in  1  drive bus from reg[opcode[3:0]].
- reg_write_en  in  1  write bus into reg[opcode[3:0]].
- alu_exec_en  in  1  execute ALU instruction.
- ram_read_en  in  1  drive bus from ram[operand[7:0]].
- ram_write_en  in  1  write bus into ram[operand[7:0]].
- pc_read_en  in  1  drive bus from PC.
- pc_en  in  1  advance or branch the PC.
- data_out  out  16  internal bus value.
- data_out_valid  out  1  high when any read enable is high.
- flags  out  4  {V,N,C,Z} = bits [3:0] as: [0]=Z, [1]=C, [2]=N, [3]=V.
- pc  out  16  current PC.

Behaviour:
- Reset (async) clears all registers, flags and the PC to 0; data_out then equals data_in. RAM contents are not reset; reads of unwritten RAM are undefined.
- Bus is combinational, priority reg_read_en > ram_read_en > pc_read_en > data_in. data_out = bus.
- Reads have zero latency. Writes commit on the rising edge using the bus value of that cycle. A RAM-to-register move (ram_read_en + reg_write_en) therefore completes in one cycle.
- ALU: when alu_exec_en=1 and opcode[15:12]=0x1, the function is opcode[11:8], with rd=operand[11:8], rs1=operand[7:4], rs2=operand[3:0]. Operands are read from the pre-edge register values.
  - Functions: 0 ADD, 1 SUB (rs1-rs2), 2 AND, 3 OR, 4 XOR, 5 NOT rs1, 6 SHL rs1 by 1, 7 SHR rs1 by 1 (logical), 8 MOV rs1, 9 CMP (SUB without writeback).
  - Functions 10-15 are no-ops: no register write, no flag change.
- Flags update only on a valid ALU execution, otherwise hold.
  - Z = result==0; N = result[15].
  - C: ADD uses bit 16 of the 17-bit sum; SUB/CMP C=1 on borrow (rs1<rs2 unsigned); SHL/SHR C = the bit shifted out; other functions C=0.
  - V: signed overflow for ADD/SUB/CMP, 0 otherwise.
- alu_exec_en with opcode[15:12]≠0x1 has no effect.
- Same-edge collision: alu_exec_en writeback and reg_write_en to the same register → the ALU result wins. Different registers → both are written.
- PC: on a pc_en edge, if opcode[15:12]=0x7 the branch condition is opcode[11:8]:
  - 0 JMP (always), 1 JZ, 2 JNZ, 3 JC, 4 JNC; other codes never taken.
  - Taken → PC=operand; otherwise PC=PC+1.
  - A non-PC opcode → PC=PC+1.
  - PC wraps 0xFFFF→0x0000.
  - The branch condition uses the flags before that edge, even if the ALU updates the flags on the same edge.
- pc_en low → PC holds.
- Reset asserted mid-operation clears state immediately; a write pending on the next edge is dropped.

Test Plan:
- Reset then release → pc=0, flags=0; reg_read_en with opcode[3:0]=5 → data_out=0, data_out_valid=1.
- data_in=0x1234, opcode=0x4100, operand=0x0010, ram_write_en → next cycle ram_read_en with operand=0x0010 gives data_out=0x1234. Then opcode=0x9203 with ram_read_en+reg_write_en → reg3=0x1234.
- Load reg1=0xFFFF and reg2=0x0001, then ADD (opcode=0x1000, operand=0x0312) → reg3=0x0000, flags Z=1, C=1, N=0, V=0.
- CMP reg2,reg1 (opcode=0x1900, operand=0x0021) → C=1, Z=0, N=0, V=0; reg0 unchanged. JC (opcode=0x7300, operand=0x0040) with pc_en → pc=0x0040.
- Flags Z=0, JZ (opcode=0x7100) with pc_en → pc increments by 1. pc_en held low → pc holds. pc=0xFFFF with a non-branch pc_en → pc=0x0000.
- Same cycle: alu_exec_en MOV to rd=4 and reg_write_en with opcode[3:0]=4 → reg4 = ALU result. Reset asserted mid-cycle → pc=0 immediately.
